diag_ram_bist: RTL and testbench
================================

Name: diag_ram_bist

Overview:
Parametrised on-chip RAM with an Avalon-MM pipelined slave (waitrequest/readdatavalid) and configurable read latency.
Adds a built-in March-style self-test engine for board diagnostics.
Sits on the Nios II data master as the diagnostic work RAM; the BIST is started by a PIO/CSR bit and reports pass/fail plus the first failing word address.

Parameters:
DATA_WIDTH, 32, word width; multiple of 8.
ADDR_WIDTH, 16, word address width.
DEPTH, 51200, words implemented; must be <= 2**ADDR_WIDTH.
READ_LATENCY, 1, cycles from read accept to readdatavalid; legal values 1 or 2.
PATTERN_BYTE, 8'h55, BIST background byte, replicated to DATA_WIDTH.
INJECT_FAULT_ADDR, -1, if >= 0, bit 0 of every write to that address is stored as 0 (stuck-at-0 model); -1 disables it.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
address  in  ADDR_WIDTH  word address
byteenable  in  DATA_WIDTH/8  byte lane enables for writes
chipselect  in  1  slave select
read  in  1  read request
write  in  1  write request
writedata  in  DATA_WIDTH  write data
clken  in  1  clock enable; low freezes the slave
waitrequest  out  1  stall, = bist_busy | ~clken
readdata  out  DATA_WIDTH  read data
readdatavalid  out  1  one-cycle pulse per accepted read
bist_start  in  1  rising-edge request to run the BIST
bist_busy  out  1  BIST in progress
bist_done  out  1  sticky; high after BIST completes, cleared by the next accepted start
bist_pass  out  1  result; valid when bist_done=1
bist_fail_addr  out  ADDR_WIDTH  first mismatching address; 0 on pass

Behaviour:
- Reset (async assert, sync deassert by system): readdata=0, readdatavalid=0, bist_busy=0, bist_done=0, bist_pass=0, bist_fail_addr=0; FSM=IDLE; read pipeline flushed. Memory contents are not reset.
- Host write accepted when chipselect & write & ~waitrequest.
  - Only lanes with byteenable=1 are updated, on the same edge.
- Host read accepted when chipselect & read & ~waitrequest.
  - readdata/readdatavalid appear exactly READ_LATENCY cycles after accept.
  - Fully pipelined: one read per cycle, data returned in order.
- read & write together: illegal. The write is performed, no readdatavalid is generated, and a simulation assertion fires.
- Address >= DEPTH: write is dropped; read returns 0 with normal readdatavalid timing.
- clken=0: no accepts; the read pipeline holds its state and readdatavalid is held low. The pipeline resumes when clken=1. The BIST FSM also stalls on clken=0.
- bist_start edge detection: a registered 0->1 transition on bist_start is a start request. It is ignored unless the FSM is in IDLE or DONE.
- FSM states: IDLE, DRAIN, FILL, UP_RD, UP_CHK, DN_RD, DN_CHK, DONE.
  - IDLE/DONE -> DRAIN on a start request. bist_done and bist_pass are cleared; bist_busy=1 from the next cycle.
  - DRAIN: wait until no reads are in flight, then -> FILL with addr=0. DRAIN takes 0 extra cycles if the pipeline is empty.
  - FILL: write P to addr, increment addr. -> UP_RD after DEPTH-1.
  - UP_RD: read addr. UP_CHK: compare with P, write ~P, increment addr. After DEPTH-1 -> DN_RD with addr=DEPTH-1.
  - DN_RD: read addr. DN_CHK: compare with ~P, decrement addr. After address 0 -> DONE with pass=1.
  - Any mismatch: latch bist_fail_addr=addr, bist_pass=0, -> DONE immediately (abort).
  - DONE: bist_busy=0, bist_done=1.
- Cycle count: busy lasts exactly 5*DEPTH cycles plus any drain cycles on pass. Memory is left holding ~P.
- BIST accesses use the internal port; the host is fully stalled via waitrequest.
- reset_n asserted mid-BIST: FSM returns to IDLE asynchronously and memory contents are undefined. A fresh start runs normally.

Decomposition:
- Package diag_ram_pkg holds:
  - the bist_state_t enum;
  - the READ_LATENCY legality check function;
  - a pattern replication function.
- Sub-module diag_ram_array: byte-enabled synchronous single-port RAM (DEPTH x DATA_WIDTH, 1-cycle read). It includes the fault-injection mask and an optional output register when READ_LATENCY=2.
- The top level contains the port mux, read-valid shift register and BIST FSM.

Test Plan:
- Release reset_n -> all outputs 0, waitrequest = ~clken.
- Write 0xAABBCCDD to addr 3 (be=4'hF), then 0x11223344 with be=4'b0101, then read addr 3 -> readdata 0xAA22CC44. readdatavalid exactly 1 cycle after accept at READ_LATENCY=1 and 2 cycles after at READ_LATENCY=2.
- READ_LATENCY=2: back-to-back reads of addr 0,1,2 while clken drops for 2 cycles mid-stream -> three valid pulses in order, no loss or duplicate. Read of addr DEPTH returns 0 with a valid pulse.
- DEPTH=16: pulse bist_start -> bist_busy high for 80 cycles, then bist_done=1, bist_pass=1, bist_fail_addr=0. A read of addr 5 returns 0xAAAAAAAA.
- DEPTH=16, INJECT_FAULT_ADDR=9 -> bist_done=1, bist_pass=0, bist_fail_addr=9, with busy ending in UP_CHK of addr 9 (cycle 16+2*9+2).
- Start BIST one cycle after a read accept (READ_LATENCY=2) -> readdatavalid still delivered, busy begins after drain. Assert reset_n at cycle 30 of the BIST -> busy=0 immediately; a restart completes with pass=1.

Source files
------------

// File: rtl/diag_ram_pkg.sv
// Shared types and helpers for the diagnostic RAM with built-in self-test.
//   bist_state_t     : self-test sequencer states
//   read_latency_ok  : legality check for the READ_LATENCY parameter
//   replicate_byte   : builds a full-width background pattern from one byte
package diag_ram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_FILL,
    ST_UP_RD,
    ST_UP_CHK,
    ST_DN_RD,
    ST_DN_CHK,
    ST_DONE
  } bist_state_t;

  // Widest word the pattern helper can build; callers truncate to their width.
  localparam int MAX_DATA_WIDTH = 1024;

  function automatic bit read_latency_ok(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

  function automatic logic [MAX_DATA_WIDTH-1:0] replicate_byte(input logic [7:0] b);
    return {(MAX_DATA_WIDTH / 8){b}};
  endfunction

endpackage

// File: rtl/diag_ram_array.sv
// Byte-enabled synchronous single-port RAM, DEPTH x DATA_WIDTH.
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset (output registers only)
//   en            : clock enable; low freezes writes and the read registers
//   we, re        : write / read strobes for this cycle
//   addr, be      : word address and byte-lane enables
//   wdata         : write data
//   rdata_early   : read data one cycle after the read
//   rdata         : read data READ_LATENCY cycles after the read
// Out-of-range writes are dropped and out-of-range reads return 0.
// When INJECT_FAULT_ADDR >= 0, bit 0 written to that word is stored as 0.
module diag_ram_array
  import diag_ram_pkg::*;
#(
  parameter int DATA_WIDTH        = 32,
  parameter int ADDR_WIDTH        = 16,
  parameter int DEPTH             = 51200,
  parameter int READ_LATENCY      = 1,
  parameter int INJECT_FAULT_ADDR = -1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    en,
  input  logic                    we,
  input  logic                    re,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   rdata_early,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int                  NUM_BYTES = DATA_WIDTH / 8;
  localparam int                  IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L   = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  in_range;
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] wdata_m;
  logic [DATA_WIDTH-1:0] q1;

  assign in_range = {1'b0, addr} < DEPTH_L;
  assign idx      = addr[IDX_W-1:0];

  // Stuck-at-0 model on bit 0 of one chosen word.
  // NOTE: every signal driven in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    wdata_m = wdata;
    if (INJECT_FAULT_ADDR >= 0 && int'({1'b0, addr}) == INJECT_FAULT_ADDR) begin
      wdata_m[0] = 1'b0;
    end
  end

  // NOTE: the storage array has no reset so it can map onto block RAM; contents are undefined after reset.
  always_ff @(posedge clk) begin
    if (en && we && in_range) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata_m[8*b +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q1 <= '0;
    end else if (en && re) begin
      q1 <= in_range ? mem[idx] : '0;
    end
  end

  assign rdata_early = q1;

  generate
    if (READ_LATENCY == 2) begin : g_out_reg
      logic [DATA_WIDTH-1:0] q2;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) q2 <= '0;
        else if (en)  q2 <= q1;
      end
      assign rdata = q2;
    end else begin : g_no_out_reg
      assign rdata = q1;
    end
  endgenerate

endmodule

// File: rtl/diag_ram_bist.sv
// Diagnostic work RAM with an Avalon-MM pipelined slave and a March-style self-test.
// Ports:
//   clk, reset_n                : clock, asynchronous active-low reset
//   address, byteenable,
//   chipselect, read, write,
//   writedata                   : Avalon-MM slave request
//   clken                       : clock enable; low stalls the slave and the self-test
//   waitrequest                 : busy | ~clken
//   readdata, readdatavalid     : in-order read return, READ_LATENCY cycles after accept
//   bist_start                  : rising edge requests a self-test run
//   bist_busy, bist_done,
//   bist_pass, bist_fail_addr   : self-test status and first failing word
// Self-test: fill with P, ascending read-P/write-~P, descending read-~P.
module diag_ram_bist
  import diag_ram_pkg::*;
#(
  parameter int         DATA_WIDTH        = 32,
  parameter int         ADDR_WIDTH        = 16,
  parameter int         DEPTH             = 51200,
  parameter int         READ_LATENCY      = 1,
  parameter logic [7:0] PATTERN_BYTE      = 8'h55,
  parameter int         INJECT_FAULT_ADDR = -1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic                    chipselect,
  input  logic                    read,
  input  logic                    write,
  input  logic [DATA_WIDTH-1:0]   writedata,
  input  logic                    clken,
  output logic                    waitrequest,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    readdatavalid,
  input  logic                    bist_start,
  output logic                    bist_busy,
  output logic                    bist_done,
  output logic                    bist_pass,
  output logic [ADDR_WIDTH-1:0]   bist_fail_addr
);

  localparam int                    NUM_BYTES = DATA_WIDTH / 8;
  localparam logic [DATA_WIDTH-1:0] PAT       = DATA_WIDTH'(replicate_byte(PATTERN_BYTE));
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  bist_state_t             state;
  logic [ADDR_WIDTH-1:0]   baddr;
  logic                    start_q;
  logic                    start_req;
  logic [READ_LATENCY-1:0] rv_pipe;
  logic                    pipe_empty;
  logic                    host_wr;
  logic                    host_rd;

  logic                    b_we;
  logic                    b_re;
  logic [DATA_WIDTH-1:0]   b_wdata;

  logic                    mem_we;
  logic                    mem_re;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [NUM_BYTES-1:0]    mem_be;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH-1:0]   bist_rdata;

  assign waitrequest = bist_busy | ~clken;
  assign host_wr     = chipselect & write & ~waitrequest;
  // A simultaneous read+write performs only the write.
  assign host_rd     = chipselect & read & ~write & ~waitrequest;
  assign start_req   = bist_start & ~start_q;
  assign pipe_empty  = (rv_pipe == '0);

  // Self-test access pattern for the current state.
  always_comb begin
    b_we    = 1'b0;
    b_re    = 1'b0;
    b_wdata = PAT;
    case (state)
      ST_FILL:            b_we = 1'b1;
      ST_UP_RD, ST_DN_RD: b_re = 1'b1;
      ST_UP_CHK: begin
        b_we    = 1'b1;
        b_wdata = ~PAT;
      end
      default: ;
    endcase
  end

  // The self-test owns the RAM port whenever busy; the host is stalled then.
  assign mem_we    = bist_busy ? b_we    : host_wr;
  assign mem_re    = bist_busy ? b_re    : host_rd;
  assign mem_addr  = bist_busy ? baddr   : address;
  assign mem_be    = bist_busy ? '1      : byteenable;
  assign mem_wdata = bist_busy ? b_wdata : writedata;

  diag_ram_array #(
    .DATA_WIDTH       (DATA_WIDTH),
    .ADDR_WIDTH       (ADDR_WIDTH),
    .DEPTH            (DEPTH),
    .READ_LATENCY     (READ_LATENCY),
    .INJECT_FAULT_ADDR(INJECT_FAULT_ADDR)
  ) u_array (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (clken),
    .we         (mem_we),
    .re         (mem_re),
    .addr       (mem_addr),
    .be         (mem_be),
    .wdata      (mem_wdata),
    .rdata_early(bist_rdata),
    .rdata      (readdata)
  );

  // Read-valid shift register tracks host reads in flight; frozen while clken is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   rv_pipe <= '0;
    else if (clken) rv_pipe <= READ_LATENCY'({rv_pipe, host_rd});
  end

  assign readdatavalid = rv_pipe[READ_LATENCY-1] & clken;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      baddr          <= '0;
      start_q        <= 1'b0;
      bist_busy      <= 1'b0;
      bist_done      <= 1'b0;
      bist_pass      <= 1'b0;
      bist_fail_addr <= '0;
    end else if (clken) begin
      start_q <= bist_start;
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start_req) begin
            bist_busy      <= 1'b1;
            bist_done      <= 1'b0;
            bist_pass      <= 1'b0;
            bist_fail_addr <= '0;
            baddr          <= '0;
            // Skip the drain state entirely when no host read is outstanding.
            state          <= (pipe_empty && !host_rd) ? ST_FILL : ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (pipe_empty) state <= ST_FILL;
        end
        ST_FILL: begin
          if (baddr == LAST_ADDR) begin
            baddr <= '0;
            state <= ST_UP_RD;
          end else begin
            baddr <= baddr + 1'b1;
          end
        end
        ST_UP_RD: state <= ST_UP_CHK;
        ST_UP_CHK: begin
          if (bist_rdata != PAT) begin
            bist_fail_addr <= baddr;
            bist_busy      <= 1'b0;
            bist_done      <= 1'b1;
            state          <= ST_DONE;
          end else if (baddr == LAST_ADDR) begin
            state <= ST_DN_RD;
          end else begin
            baddr <= baddr + 1'b1;
            state <= ST_UP_RD;
          end
        end
        ST_DN_RD: state <= ST_DN_CHK;
        ST_DN_CHK: begin
          if (bist_rdata != ~PAT) begin
            bist_fail_addr <= baddr;
            bist_busy      <= 1'b0;
            bist_done      <= 1'b1;
            state          <= ST_DONE;
          end else if (baddr == '0) begin
            bist_busy <= 1'b0;
            bist_done <= 1'b1;
            bist_pass <= 1'b1;
            state     <= ST_DONE;
          end else begin
            baddr <= baddr - 1'b1;
            state <= ST_DN_RD;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  a_rw_together : assert property (@(posedge clk) disable iff (!reset_n)
    !(chipselect && read && write && !waitrequest));

  a_latency_legal : assert property (@(posedge clk) read_latency_ok(READ_LATENCY));

endmodule

// File: tb/tb_diag_ram_bist.sv
// Self-checking bench: three DUTs (READ_LATENCY 1, 2, and 2 with a stuck bit at word 9),
// DEPTH=16, driven with identical host traffic and compared against a memory model.
module tb_diag_ram_bist;

  localparam int ND  = 3;
  localparam int DEP = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] address;
  logic [3:0]  byteenable;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic        clken;
  logic        bist_start;

  logic        waitreq   [ND];
  logic [31:0] rdata     [ND];
  logic        rdv       [ND];
  logic        busy      [ND];
  logic        done      [ND];
  logic        pass      [ND];
  logic [15:0] fail_addr [ND];

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    diag_ram_bist #(
      .DATA_WIDTH       (32),
      .ADDR_WIDTH       (16),
      .DEPTH            (DEP),
      .READ_LATENCY     ((g == 0) ? 1 : 2),
      .PATTERN_BYTE     (8'h55),
      .INJECT_FAULT_ADDR((g == 2) ? 9 : -1)
    ) u_dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .address       (address),
      .byteenable    (byteenable),
      .chipselect    (chipselect),
      .read          (read),
      .write         (write),
      .writedata     (writedata),
      .clken         (clken),
      .waitrequest   (waitreq[g]),
      .readdata      (rdata[g]),
      .readdatavalid (rdv[g]),
      .bist_start    (bist_start),
      .bist_busy     (busy[g]),
      .bist_done     (done[g]),
      .bist_pass     (pass[g]),
      .bist_fail_addr(fail_addr[g])
    );
  end

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
    logic [31:0] exp;    // expected read data, fault-free DUTs
    logic [31:0] exp_f;  // expected read data, faulty DUT
  } vec_t;

  typedef struct {
    logic [31:0] data;
    longint      due;
  } exp_t;

  int          rl [ND] = '{1, 2, 2};
  int          checks = 0;
  int          errors = 0;
  longint      en_count = 0;
  int          busy_cnt [ND];
  int          vcnt [ND];
  int          vbase [ND];
  logic [31:0] cur_exp [ND];
  bit          use_table = 1'b0;
  logic [31:0] mem_m [2][DEP];  // [0] fault-free model, [1] stuck-at-0 at bit 0 of word 9
  exp_t        sbq [ND][$];
  vec_t        vecs [14];

  task automatic check(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d actual=%0h expected=%0h", name, d, act, exp);
    end
  endtask

  function automatic int model_of(input int d);
    return (d == 2) ? 1 : 0;
  endfunction

  function automatic logic [31:0] model_read(input int m, input logic [15:0] a);
    return (a < DEP) ? mem_m[m][a] : 32'h0;
  endfunction

  task automatic model_write(input int m, input logic [15:0] a, input logic [3:0] be, input logic [31:0] wd);
    if (a < DEP) begin
      for (int b = 0; b < 4; b++) if (be[b]) mem_m[m][a][8*b +: 8] = wd[8*b +: 8];
      if (m == 1 && a == 9 && be[0]) mem_m[m][a][0] = 1'b0;
    end
  endtask

  task automatic drive(input bit cs, input bit rd, input bit wr, input logic [15:0] a,
                       input logic [3:0] be, input logic [31:0] wd, input bit ce);
    chipselect = cs;
    read       = rd;
    write      = wr;
    address    = a;
    byteenable = be;
    writedata  = wd;
    clken      = ce;
  endtask

  // One clock: check outputs and record accepts just after the inputs settle, then advance.
  task automatic tick();
    bit   due;
    exp_t e;
    #1;
    for (int d = 0; d < ND; d++) begin
      if (busy[d]) busy_cnt[d]++;
      due = (sbq[d].size() > 0) && clken && (sbq[d][0].due == en_count);
      if (due || rdv[d]) begin
        check("readdatavalid", d, 64'(rdv[d]), 64'(due));
        if (rdv[d]) vcnt[d]++;
        if (sbq[d].size() > 0) begin
          e = sbq[d].pop_front();
          if (due && rdv[d]) check("readdata", d, 64'(rdata[d]), 64'(e.data));
        end
      end
      if (chipselect && !waitreq[d]) begin
        if (write) begin
          if (d != 1) model_write(model_of(d), address, byteenable, writedata);
        end else if (read) begin
          e.data = use_table ? cur_exp[d] : model_read(model_of(d), address);
          e.due  = en_count + rl[d];
          sbq[d].push_back(e);
        end
      end
    end
    @(posedge clk);
    if (clken) en_count++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 16'h0, 4'h0, 32'h0, 1);
    repeat (n) tick();
  endtask

  task automatic run_bist(input int cycles);
    for (int d = 0; d < ND; d++) busy_cnt[d] = 0;
    drive(0, 0, 0, 16'h0, 4'h0, 32'h0, 1);
    bist_start = 1'b1;
    tick();
    bist_start = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      if (i == 10) for (int d = 0; d < ND; d++) check("waitrequest_busy", d, 64'(waitreq[d]), 64'd1);
      tick();
    end
  endtask

  task automatic check_result(input string tag);
    for (int d = 0; d < ND; d++) begin
      check({tag, "_done"}, d, 64'(done[d]), 64'd1);
      check({tag, "_busy"}, d, 64'(busy[d]), 64'd0);
      check({tag, "_pass"}, d, 64'(pass[d]), (d == 2) ? 64'd0 : 64'd1);
      check({tag, "_fail_addr"}, d, 64'(fail_addr[d]), (d == 2) ? 64'd9 : 64'd0);
    end
  endtask

  initial begin
    vecs[0]  = '{1, 16'd3,     4'hF, 32'hAABBCCDD, 32'h0,        32'h0};
    vecs[1]  = '{1, 16'd3,     4'h5, 32'h11223344, 32'h0,        32'h0};
    vecs[2]  = '{0, 16'd3,     4'h0, 32'h0,        32'hAA22CC44, 32'hAA22CC44};
    vecs[3]  = '{1, 16'd9,     4'hF, 32'h12345679, 32'h0,        32'h0};
    vecs[4]  = '{0, 16'd9,     4'h0, 32'h0,        32'h12345679, 32'h12345678};
    vecs[5]  = '{1, 16'd9,     4'h1, 32'h000000FF, 32'h0,        32'h0};
    vecs[6]  = '{0, 16'd9,     4'h0, 32'h0,        32'h123456FF, 32'h123456FE};
    vecs[7]  = '{1, 16'd16,    4'hF, 32'hDEADBEEF, 32'h0,        32'h0};
    vecs[8]  = '{0, 16'd16,    4'h0, 32'h0,        32'h0,        32'h0};
    vecs[9]  = '{0, 16'hFFFF,  4'h0, 32'h0,        32'h0,        32'h0};
    vecs[10] = '{1, 16'd0,     4'hC, 32'hCAFEBABE, 32'h0,        32'h0};
    vecs[11] = '{0, 16'd0,     4'h0, 32'h0,        32'hCAFE0000, 32'hCAFE0000};
    vecs[12] = '{0, 16'd9,     4'h0, 32'h0,        32'h123456FF, 32'h123456FE};
    vecs[13] = '{0, 16'd3,     4'h0, 32'h0,        32'hAA22CC44, 32'hAA22CC44};

    for (int d = 0; d < ND; d++) begin
      busy_cnt[d] = 0;
      vcnt[d]     = 0;
    end
    bist_start = 1'b0;
    reset_n    = 1'b0;
    drive(0, 0, 0, 16'h0, 4'h0, 32'h0, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1;
    for (int d = 0; d < ND; d++) begin
      check("rst_readdata", d, 64'(rdata[d]), 64'd0);
      check("rst_readdatavalid", d, 64'(rdv[d]), 64'd0);
      check("rst_busy", d, 64'(busy[d]), 64'd0);
      check("rst_done", d, 64'(done[d]), 64'd0);
      check("rst_pass", d, 64'(pass[d]), 64'd0);
      check("rst_fail_addr", d, 64'(fail_addr[d]), 64'd0);
      check("rst_waitreq_clken0", d, 64'(waitreq[d]), 64'd1);
    end
    clken = 1'b1;
    #1;
    for (int d = 0; d < ND; d++) check("rst_waitreq_clken1", d, 64'(waitreq[d]), 64'd0);
    @(negedge clk);

    // Known contents everywhere before any read.
    for (int a = 0; a < DEP; a++) begin
      drive(1, 0, 1, 16'(a), 4'hF, 32'h0, 1);
      tick();
    end

    // Directed vectors: byte lanes, stuck bit, out-of-range, pipelined reads.
    use_table = 1'b1;
    foreach (vecs[i]) begin
      drive(1, !vecs[i].wr, vecs[i].wr, vecs[i].addr, vecs[i].be, vecs[i].data, 1);
      cur_exp[0] = vecs[i].exp;
      cur_exp[1] = vecs[i].exp;
      cur_exp[2] = vecs[i].exp_f;
      tick();
    end
    idle(4);
    use_table = 1'b0;

    // Back-to-back reads with clken dropping for two cycles mid-stream.
    for (int d = 0; d < ND; d++) vbase[d] = vcnt[d];
    drive(1, 1, 0, 16'd0, 4'h0, 32'h0, 1); tick();
    drive(1, 1, 0, 16'd1, 4'h0, 32'h0, 1); tick();
    drive(1, 1, 0, 16'd2, 4'h0, 32'h0, 0); tick();
    tick();
    drive(1, 1, 0, 16'd2, 4'h0, 32'h0, 1); tick();
    idle(4);
    for (int d = 0; d < ND; d++) check("stall_valid_count", d, 64'(vcnt[d] - vbase[d]), 64'd3);

    // Random host traffic against the model.
    for (int i = 0; i < 400; i++) begin
      int op;
      op = $urandom_range(0, 2);
      drive($urandom_range(0, 7) != 0, op == 1, op == 2, 16'($urandom_range(0, 19)),
            4'($urandom), 32'($urandom), $urandom_range(0, 5) != 0);
      tick();
    end
    idle(4);
    for (int d = 0; d < ND; d++) check("random_queue_empty", d, 64'(sbq[d].size()), 64'd0);

    // Full self-test: 5*DEPTH busy cycles on pass, abort at UP_CHK of word 9 on the faulty DUT.
    run_bist(100);
    check("bist_busy_len", 0, 64'(busy_cnt[0]), 64'(5 * DEP));
    check("bist_busy_len", 1, 64'(busy_cnt[1]), 64'(5 * DEP));
    check("bist_busy_len", 2, 64'(busy_cnt[2]), 64'(DEP + 2 * 9 + 2));
    check_result("bist");

    // Memory left at ~P (word 5 precedes the fault on the faulty DUT).
    use_table = 1'b1;
    for (int d = 0; d < ND; d++) cur_exp[d] = 32'hAAAAAAAA;
    drive(1, 1, 0, 16'd5, 4'h0, 32'h0, 1);
    tick();
    idle(4);

    // Start one cycle after a read accept: the read still returns, busy grows by the drain.
    for (int d = 0; d < ND; d++) begin
      vbase[d]    = vcnt[d];
      busy_cnt[d] = 0;
    end
    drive(1, 1, 0, 16'd5, 4'h0, 32'h0, 1);
    tick();
    run_bist(100);
    use_table = 1'b0;
    for (int d = 0; d < ND; d++) begin
      int base;
      base = (d == 2) ? (DEP + 2 * 9 + 2) : (5 * DEP);
      check("drain_valid_count", d, 64'(vcnt[d] - vbase[d]), 64'd1);
      check("drain_busy_len_ok", d,
            64'((busy_cnt[d] > base) && (busy_cnt[d] <= base + rl[d] + 1)), 64'd1);
    end
    check_result("drain");

    // Reset in the middle of a run, then a clean restart.
    run_bist(30);
    reset_n = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) begin
      check("midrst_busy", d, 64'(busy[d]), 64'd0);
      check("midrst_done", d, 64'(done[d]), 64'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int d = 0; d < ND; d++) sbq[d].delete();
    idle(2);
    run_bist(100);
    check("restart_busy_len", 0, 64'(busy_cnt[0]), 64'(5 * DEP));
    check("restart_busy_len", 2, 64'(busy_cnt[2]), 64'(DEP + 2 * 9 + 2));
    check_result("restart");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
